// File: rtl/sram_pkg.sv
// Shared constants and FSM encodings for the 16x32 register-file SRAM
// and its read/write side blocks.
package sram_pkg;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/word_mux16_32.sv
// Combinational word selector over the flat SRAM contents bus:
// word i lives at mem[WORD_W*i +: WORD_W].
module word_mux16_32 #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic [WORD_W*DEPTH-1:0] mem,
  input  logic [ADDR_W-1:0]       sel,
  output logic [WORD_W-1:0]       word
);

  // Pick the selected word out of the flat bus
  assign word = mem[sel*WORD_W +: WORD_W];

endmodule

// File: rtl/sram16_32_reader.sv
// Burst read engine: streams a run of consecutive SRAM words (wrapping at
// the top address) to a consumer over a valid/ready handshake.
module sram16_32_reader
  import sram_pkg::*;
#(
  parameter int WORD_W = sram_pkg::WORD_W,
  parameter int DEPTH  = sram_pkg::DEPTH,
  parameter int ADDR_W = sram_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_W*DEPTH-1:0]  mem,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        req_add,
  input  logic [ADDR_W-1:0]        req_len,
  output logic                     busy,
  output logic [WORD_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     done
);

  state_e              r_state;
  logic [WORD_W-1:0]   r_dout;
  logic                r_valid;
  logic                r_done;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_rem;

  logic [ADDR_W-1:0]   w_ptr_next;
  logic [ADDR_W-1:0]   w_sel;
  logic [WORD_W-1:0]   w_word;

  // Next address wraps naturally in ADDR_W bits (15 -> 0)
  assign w_ptr_next = r_ptr + ADDR_W'(1);
  assign w_sel      = (r_state == ST_SEND) ? w_ptr_next : req_add;

  word_mux16_32 #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .mem  (mem),
    .sel  (w_sel),
    .word (w_word)
  );

  // Burst FSM, address/remaining counters and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_dout  <= w_word;
            r_ptr   <= req_add;
            r_rem   <= req_len;
            r_valid <= 1'b1;
            r_state <= ST_SEND;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // mem is only sampled on a transfer, so a stalled word is a snapshot
          if (r_valid && dout_ready) begin
            if (r_rem != '0) begin
              r_ptr  <= w_ptr_next;
              r_dout <= w_word;
              r_rem  <= r_rem - ADDR_W'(1);
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (r_state == ST_SEND);
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_sram16_32_reader.sv
// Self-checking bench for sram16_32_reader: burst-level reference model
// compared every cycle, plus directed literal checks.
module tb_sram16_32_reader;

  logic         clk;
  logic         reset;
  logic [511:0] mem;
  logic         req;
  logic [3:0]   req_add;
  logic [3:0]   req_len;
  logic         busy;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         done;

  logic [31:0]  words [16];

  int checks;
  int errors;

  sram16_32_reader dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem),
    .req        (req),
    .req_add    (req_add),
    .req_len    (req_len),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem = '0;
    for (int i = 0; i < 16; i++) mem[32*i +: 32] = words[i];
  end

  // Reference model: a burst is (start, length N, words sent k)
  bit          m_init;
  bit          m_busy;
  bit          m_valid;
  bit          m_done;
  logic [31:0] m_dout;
  int          m_start;
  int          m_n;
  int          m_k;

  initial begin
    m_init = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
    m_dout = 32'h0; m_start = 0; m_n = 0; m_k = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
      m_dout = 32'h0; m_k = 0; m_n = 0;
    end else if (m_init) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (req) begin
          m_start = int'(req_add);
          m_n     = int'(req_len) + 1;
          m_k     = 0;
          m_dout  = words[m_start];
          m_valid = 1'b1;
          m_busy  = 1'b1;
        end
      end else if (dout_ready) begin
        m_k = m_k + 1;
        if (m_k == m_n) begin
          m_busy  = 1'b0;
          m_valid = 1'b0;
          m_done  = 1'b1;
        end else begin
          m_dout = words[(m_start + m_k) % 16];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init) begin
      check("model_valid", {31'd0, dout_valid}, {31'd0, m_valid});
      check("model_busy",  {31'd0, busy},       {31'd0, m_busy});
      check("model_done",  {31'd0, done},       {31'd0, m_done});
      check("model_dout",  dout,                m_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [3:0] a, input logic [3:0] l);
    req = 1'b1; req_add = a; req_len = l;
    tick();
    req = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 16; i++) words[i] = 32'h1000_0000 + 32'(i);
    reset = 1'b1; req = 1'b0; req_add = 4'd0; req_len = 4'd0; dout_ready = 1'b1;
    tick(); tick();
    check("rst_dout",  dout, 32'h0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();

    // Two-word burst from address 3
    start(4'd3, 4'd1);
    check("b1_w0", dout, 32'h1000_0003);
    check("b1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("b1_w1", dout, 32'h1000_0004);
    tick();
    check("b1_done", {31'd0, done}, 32'd1);
    check("b1_novalid", {31'd0, dout_valid}, 32'd0);
    tick();
    check("b1_done_clr", {31'd0, done}, 32'd0);

    // Wrap-around 14,15,0,1
    start(4'd14, 4'd3);
    check("wr_w0", dout, 32'h1000_000E);
    tick(); check("wr_w1", dout, 32'h1000_000F);
    tick(); check("wr_w2", dout, 32'h1000_0000);
    tick(); check("wr_w3", dout, 32'h1000_0001);
    tick(); check("wr_done", {31'd0, done}, 32'd1);
    tick();

    // Backpressure with writes during the stall
    dout_ready = 1'b0;
    start(4'd5, 4'd1);
    check("bp_w0", dout, 32'h1000_0005);
    words[5] = 32'hDEAD_BEEF;
    words[6] = 32'hCAFE_0006;
    tick(); tick(); tick();
    check("bp_hold", dout, 32'h1000_0005);
    check("bp_valid", {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    tick();
    check("bp_w1_new", dout, 32'hCAFE_0006);
    tick();
    check("bp_done", {31'd0, done}, 32'd1);
    words[5] = 32'h1000_0005;
    words[6] = 32'h1000_0006;
    tick();

    // Full 16-word burst; done in cycle 17
    start(4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      check("full_word", dout, 32'h1000_0000 + 32'(i));
      tick();
    end
    check("full_done", {31'd0, done}, 32'd1);
    tick();

    // req during burst ignored; req held into done cycle starts a new burst
    start(4'd2, 4'd2);
    req = 1'b1; req_add = 4'd9; req_len = 4'd0;
    check("rq_w0", dout, 32'h1000_0002);
    tick(); check("rq_w1", dout, 32'h1000_0003);
    tick(); check("rq_w2", dout, 32'h1000_0004);
    tick(); check("rq_done", {31'd0, done}, 32'd1);
    tick();
    req = 1'b0;
    check("rq_new_w0", dout, 32'h1000_0009);
    check("rq_new_valid", {31'd0, dout_valid}, 32'd1);
    tick(); check("rq_new_done", {31'd0, done}, 32'd1);
    tick();

    // Reset mid-burst
    start(4'd0, 4'd7);
    check("rs_w0", dout, 32'h1000_0000);
    tick(); check("rs_w1", dout, 32'h1000_0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_valid", {31'd0, dout_valid}, 32'd0);
    check("rs_busy",  {31'd0, busy}, 32'd0);
    check("rs_dout",  dout, 32'h0);
    tick();
    check("rs_nodone", {31'd0, done}, 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram16_32_reader.md
# sram16_32_reader

Burst read engine for the 16×32 register-file SRAM. It reads the SRAM's flat 512-bit `mem` bus and streams a requested run of consecutive words to a consumer over a valid/ready handshake. It sits beside the SRAM write port and is the read side of the same storage, so the SRAM itself stays write-only. Addressing matches the write port: 4-bit word address, and word `i` occupies `mem[32*i+31:32*i]`.

## Interface
Parameters:
- `WORD_W`, 32, data word width
- `DEPTH`, 16, number of words in the SRAM
- `ADDR_W`, 4, word address width; must equal log2(`DEPTH`)

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem`  in  `WORD_W*DEPTH` (512)  flat SRAM contents
- `req`  in  1  start-burst request
- `req_add`  in  4  first word address of the burst
- `req_len`  in  4  burst length minus 1: 0 means 1 word, 15 means 16 words
- `busy`  out  1  high while a burst is in progress
- `dout`  out  32  current output word
- `dout_valid`  out  1  `dout` holds a word not yet accepted
- `dout_ready`  in  1  consumer accepts `dout` on this edge if `dout_valid` is high
- `done`  out  1  one-cycle pulse after the last word of a burst is accepted

## Operation
- FSM states:
  - IDLE (encoding 0)
  - SEND (encoding 1)
- `busy` equals (state == SEND).
- Internal registers:
  - `ptr`: 4-bit address of the word currently in `dout`
  - `rem`: 4-bit count of words remaining after the current one
- Burst acceptance, in IDLE with `req`=1 at an edge:
  - `dout` <= word[`req_add`], `ptr` <= `req_add`, `rem` <= `req_len`
  - `dout_valid` <= 1; state goes to SEND
- In SEND, a transfer is an edge where `dout_valid` && `dout_ready`.
  - Transfer with `rem` != 0: `ptr` <= `ptr`+1 mod 16 (15 wraps to 0), `dout` <= word[`ptr`+1], `rem` <= `rem`-1, `dout_valid` stays 1.
  - Transfer with `rem` == 0: `dout_valid` <= 0, `done` <= 1, state goes to IDLE.
- Stall (`dout_valid`=1, `dout_ready`=0): `dout`, `ptr` and `rem` hold. `mem` is not re-sampled, so an SRAM write to the word already in `dout` does not change `dout`.
- Snapshot rule: each word is captured from `mem` at the edge it is loaded into `dout`. A write landing before that edge is seen; a write after it is not.
- `req` while `busy`=1 is ignored and not queued. `req_add`/`req_len` are sampled only at acceptance.
- `done` clears to 0 on the edge after it rises.
- `reset`=1 at an edge:
  - state goes to IDLE
  - `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `ptr`=0, `rem`=0
  - any in-progress burst is abandoned and no `done` is produced
  - `reset` takes priority over `req` and over transfers

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `done`=0.
- Latency: request accepted at edge E means `dout_valid`=1 with the first word from the cycle after E.
- Throughput: 1 word per cycle while `dout_ready` is held high. An N-word burst with no stalls has:
  - `dout_valid` high for exactly N cycles
  - `done` high in cycle N+1
- In the `done` cycle `busy`=0, so a `req` in that cycle is accepted; the new first word is valid the following cycle, giving a one-cycle bubble between bursts.
- All outputs are registered or decoded from a register; there is no combinational path from `req` or `dout_ready` to any output.

## Structure
- Package `sram_pkg`:
  - `WORD_W`=32, `DEPTH`=16, `ADDR_W`=4
  - FSM state encodings `ST_IDLE`, `ST_SEND`
  - shared with the SRAM write-side blocks
- One sub-module, `word_mux16_32`: combinational 16:1 selector returning `mem[32*sel+31:32*sel]`.
  - Instantiated once.
  - Its select is `req_add` in IDLE and `ptr`+1 in SEND.
- Top level holds the FSM, `ptr`/`rem` counters and the output register.

## Test plan
- Preload word i = 0x1000_0000+i. Burst `req_add`=3, `req_len`=1, `dout_ready`=1 → `dout` 0x10000003, then 0x10000004, then `done`=1 with `dout_valid`=0.
- Wrap-around: `req_add`=14, `req_len`=3 → words 14, 15, 0, 1 in consecutive cycles, then `done`.
- Backpressure: drop `dout_ready` for 3 cycles on the first word and write 0xDEADBEEF to that word during the stall → `dout` stays 0x1000000x; the next word comes out after `dout_ready` returns.
- Full burst: `req_add`=0, `req_len`=15 → 16 words 0x10000000..0x1000000F, `done` in cycle 17.
- Request handling: `req` during a burst is ignored (no change to the stream); `req` asserted in the `done` cycle starts a new burst with its first word valid the next cycle.
- Reset mid-burst: assert `reset` after the 2nd word → next cycle `dout_valid`=0, `busy`=0, `dout`=0, and no `done` pulse.
